morse_key_sequencer: RTL and testbench

- Turns one Morse character (dot/dash pattern plus length) into a timed key waveform using standard Morse unit timing.
- Paced by the one-cycle unit-tick pulse from the baud/tick generator, e.g. clk_bps or clk_bps2.
- Sits between the character encoder (upstream, valid/ready handshake) and the tone/LED driver (downstream, key_out).

---
 rtl/morse_key_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_key_sequencer                                          |
// | Description : Plays one Morse character as a unit-tick-timed key waveform, |
// |               followed by a letter or word gap.                            |
// | Options     : MORSE_ABORT_EN enables the synchronous abort input.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_key_sequencer #(
  parameter int MAX_LEN    = 5,
  parameter int DASH_UNITS = 3,
  parameter int LGAP_UNITS = 3,
  parameter int WGAP_UNITS = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               unit_tick,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [MAX_LEN-1:0] sym_code,
  input  logic [2:0]         sym_len,
  input  logic               word_gap,
  input  logic               abort,
  output logic               key_out,
  output logic               busy,
  output logic               done
);

  // Elaboration-time range checks: all unit counts must fit the 3-bit counter.
  if (MAX_LEN < 1 || MAX_LEN > 7) begin : g_bad_max_len
    $error("morse_key_sequencer: MAX_LEN must be in 1..7");
  end
  if (DASH_UNITS < 1 || DASH_UNITS > 7) begin : g_bad_dash_units
    $error("morse_key_sequencer: DASH_UNITS must be in 1..7");
  end
  if (LGAP_UNITS < 1 || LGAP_UNITS > 7) begin : g_bad_lgap_units
    $error("morse_key_sequencer: LGAP_UNITS must be in 1..7");
  end
  if (WGAP_UNITS < 1 || WGAP_UNITS > 7) begin : g_bad_wgap_units
    $error("morse_key_sequencer: WGAP_UNITS must be in 1..7");
  end

  localparam logic [2:0] MAX_LEN_C = 3'(MAX_LEN);
  localparam logic [2:0] DASH_M1   = 3'(DASH_UNITS - 1);
  localparam logic [2:0] LGAP_M1   = 3'(LGAP_UNITS - 1);
  localparam logic [2:0] WGAP_M1   = 3'(WGAP_UNITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    MARK  = 3'd2,
    SPACE = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [2:0]         cnt, cnt_d;
  logic [2:0]         idx, idx_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         gap_m1_q, gap_m1_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic               wgap_q, wgap_d;
  logic               done_d;
  logic               key_d;

  logic               accept;
  logic [2:0]         len_clamped;
  logic               is_dash;
  logic               last_elem;
  logic [2:0]         mark_m1;

  assign sym_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef MORSE_ABORT_EN
  assign accept = sym_valid & sym_ready & ~abort;
`else
  assign accept = sym_valid & sym_ready;
  logic unused_abort;
  assign unused_abort = abort;
`endif

  assign len_clamped = (sym_len > MAX_LEN_C) ? MAX_LEN_C : sym_len;

  // Select the current element bit without a variable part-select.
  always_comb begin
    is_dash = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == 3'(i)) begin
        is_dash = code_q[i];
      end
    end
  end

  assign last_elem = ({1'b0, idx} + 4'd1) >= {1'b0, len_q};
  assign mark_m1   = is_dash ? DASH_M1 : 3'd0;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    len_d    = len_q;
    code_d   = code_q;
    wgap_d   = wgap_q;
    gap_m1_d = gap_m1_q;
    done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          code_d = sym_code;
          len_d  = len_clamped;
          wgap_d = word_gap;
          cnt_d  = 3'd0;
          idx_d  = 3'd0;
          if (len_clamped == 3'd0) begin
            state_d  = GAP;
            gap_m1_d = WGAP_M1;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        if (unit_tick) begin
          state_d = MARK;
        end
      end
      MARK: begin
        if (unit_tick) begin
          if (cnt == mark_m1) begin
            cnt_d = 3'd0;
            if (last_elem) begin
              state_d  = GAP;
              gap_m1_d = wgap_q ? WGAP_M1 : LGAP_M1;
            end else begin
              state_d = SPACE;
            end
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      SPACE: begin
        if (unit_tick) begin
          state_d = MARK;
          idx_d   = idx + 3'd1;
        end
      end
      GAP: begin
        if (unit_tick) begin
          if (cnt == gap_m1_q) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase

`ifdef MORSE_ABORT_EN
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      idx_d   = 3'd0;
      done_d  = 1'b0;
    end
`endif

    // Key is a registered image of the MARK state, so it tracks tick edges.
    key_d = (state_d == MARK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      idx      <= 3'd0;
      len_q    <= 3'd0;
      gap_m1_q <= 3'd0;
      code_q   <= '0;
      wgap_q   <= 1'b0;
      key_out  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      len_q    <= len_d;
      gap_m1_q <= gap_m1_d;
      code_q   <= code_d;
      wgap_q   <= wgap_d;
      key_out  <= key_d;
      done     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_morse_key_sequencer                                       |
// | Description : Self-checking bench for morse_key_sequencer using a per-tick |
// |               key-level queue model; honours MORSE_ABORT_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_morse_key_sequencer;

  localparam int TICK_DIV = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       unit_tick = 1'b0;
  logic       sym_valid = 1'b0;
  logic [4:0] sym_code  = 5'd0;
  logic [2:0] sym_len   = 3'd0;
  logic       word_gap  = 1'b0;
  logic       abort     = 1'b0;
  logic       sym_ready;
  logic       key_out;
  logic       busy;
  logic       done;

  morse_key_sequencer #(
    .MAX_LEN   (5),
    .DASH_UNITS(3),
    .LGAP_UNITS(3),
    .WGAP_UNITS(7)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .unit_tick(unit_tick),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_code (sym_code),
    .sym_len  (sym_len),
    .word_gap (word_gap),
    .abort    (abort),
    .key_out  (key_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: key level expected after each remaining unit tick of the symbol.
  bit q[$];
  bit m_key  = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_acc  = 1'b0;
  int phase  = 0;

  int key_hi_cyc = 0;
  int done_cyc   = 0;
  int idle_cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t: bound expired", name, $time);
  endtask

  // Per element: target ticks high then one low tick; then the gap ticks low.
  function automatic void build(input logic [4:0] code, input logic [2:0] len, input bit wg);
    int l;
    l = (len > 3'd5) ? 5 : int'(len);
    q.delete();
    if (l == 0) begin
      repeat (7) q.push_back(1'b0);
    end else begin
      for (int i = 0; i < l; i++) begin
        repeat (code[i] ? 3 : 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end
      repeat (wg ? 7 : 3) q.push_back(1'b0);
    end
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    m_acc  = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_key  = 1'b0;
      m_busy = 1'b0;
      return;
    end
`ifdef MORSE_ABORT_EN
    if (abort) begin
      q.delete();
      m_key  = 1'b0;
      m_busy = 1'b0;
      return;
    end
`endif
    if (q.size() == 0) begin
      if (sym_valid) begin
        build(sym_code, sym_len, word_gap);
        m_busy = 1'b1;
        m_acc  = 1'b1;
      end
    end else if (unit_tick) begin
      m_key = q.pop_front();
      if (q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    check("key_out", int'(key_out), int'(m_key));
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("sym_ready", int'(sym_ready), int'(!m_busy));
    key_hi_cyc += int'(key_out);
    done_cyc   += int'(done);
    idle_cyc   += int'(!busy && !done);
  end

  task automatic cyc();
    unit_tick = (phase == TICK_DIV - 1);
    phase     = (phase + 1) % TICK_DIV;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] c, input logic [2:0] l, input bit wg, output int qlen);
    int n;
    n = 0;
    qlen = -1;
    sym_code  = c;
    sym_len   = l;
    word_gap  = wg;
    sym_valid = 1'b1;
    do begin
      cyc();
      n++;
    end while (!m_acc && n < 200);
    sym_valid = 1'b0;
    if (m_acc) qlen = q.size();
    else bound_fail("accept_wait");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 1000) begin
      cyc();
      n++;
    end
    if (m_busy) bound_fail("idle_wait");
  endtask

  task automatic wait_key_high();
    int n;
    n = 0;
    while (!m_key && n < 100) begin
      cyc();
      n++;
    end
    if (!m_key) bound_fail("key_high_wait");
  endtask

  int k0, d0, i0, ql;

  initial begin
    repeat (3) cyc();
    rst_n = 1'b1;
    check("rst_key_out", int'(key_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sym_ready", int'(sym_ready), 1);
    repeat (5) cyc();

    // Letter A: dot, dash, letter gap
    k0 = key_hi_cyc; d0 = done_cyc;
    send(5'b00010, 3'd2, 1'b0, ql);
    check("A_model_ticks", ql, 9);
    wait_idle();
    check("A_key_high_cycles", key_hi_cyc - k0, 16);
    check("A_done_pulses", done_cyc - d0, 1);
    repeat (6) cyc();

    // Letter E with word gap, next symbol accepted in the done cycle
    k0 = key_hi_cyc; d0 = done_cyc;
    send(5'b00000, 3'd1, 1'b1, ql);
    check("E_model_ticks", ql, 9);
    i0 = idle_cyc;
    send(5'b00001, 3'd1, 1'b0, ql);
    check("E_key_high_cycles", key_hi_cyc - k0, 4);
    check("E_done_pulses", done_cyc - d0, 1);
    check("E_idle_between", idle_cyc - i0, 0);
    k0 = key_hi_cyc;
    wait_idle();
    check("T_key_high_cycles", key_hi_cyc - k0, 12);
    repeat (3) cyc();

    // Empty symbol: only the word gap
    k0 = key_hi_cyc; d0 = done_cyc;
    send(5'b11111, 3'd0, 1'b0, ql);
    check("empty_model_ticks", ql, 7);
    wait_idle();
    check("empty_key_high_cycles", key_hi_cyc - k0, 0);
    check("empty_done_pulses", done_cyc - d0, 1);
    repeat (2) cyc();

    // Length clamp: 7 requested, five dashes sent
    k0 = key_hi_cyc; d0 = done_cyc;
    send(5'b11111, 3'd7, 1'b0, ql);
    check("clamp_model_ticks", ql, 23);
    wait_idle();
    check("clamp_key_high_cycles", key_hi_cyc - k0, 60);
    check("clamp_done_pulses", done_cyc - d0, 1);
    repeat (3) cyc();

    // Abort during the second unit of a dash
    d0 = done_cyc;
    send(5'b00001, 3'd1, 1'b0, ql);
    wait_key_high();
    repeat (TICK_DIV + 1) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
`ifdef MORSE_ABORT_EN
    check("abort_key_out", int'(key_out), 0);
    check("abort_busy", int'(busy), 0);
`else
    check("noabort_key_out", int'(key_out), 1);
`endif
    wait_idle();
    repeat (8) cyc();
`ifdef MORSE_ABORT_EN
    check("abort_done_pulses", done_cyc - d0, 0);
`else
    check("noabort_done_pulses", done_cyc - d0, 1);
`endif

    // Abort together with a symbol presented in IDLE
    sym_code = 5'b00001; sym_len = 3'd1; word_gap = 1'b0;
    sym_valid = 1'b1; abort = 1'b1;
    cyc();
    sym_valid = 1'b0; abort = 1'b0;
`ifdef MORSE_ABORT_EN
    check("abort_accept_busy", int'(busy), 0);
`else
    check("noabort_accept_busy", int'(busy), 1);
`endif
    wait_idle();
    repeat (3) cyc();

    // Asynchronous reset in the middle of a dash
    send(5'b00001, 3'd1, 1'b0, ql);
    wait_key_high();
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    q.delete(); m_key = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    #1;
    check("arst_key_out", int'(key_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_sym_ready", int'(sym_ready), 1);
    check("arst_done", int'(done), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    // Letter N after reset: dash, dot
    k0 = key_hi_cyc;
    send(5'b00001, 3'd2, 1'b0, ql);
    check("N_model_ticks", ql, 9);
    wait_idle();
    check("N_key_high_cycles", key_hi_cyc - k0, 16);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
